// File: rtl/empty_scan_ctrl_if.sv
// Board-side bundle for empty_scan_ctrl: the start request, the cell probe
// (scan_idx out, cell_state back) and the write/completion signals.
// master = controller side, slave = board/requester side.
interface empty_scan_if;
  logic       start;
  logic [3:0] cell_state;
  logic [3:0] scan_idx;
  logic       busy;
  logic       we;
  logic [3:0] wr_idx;
  logic [3:0] wr_val;
  logic       done;
  logic       full;

  modport master (
    input  start, cell_state,
    output scan_idx, busy, we, wr_idx, wr_val, done, full
  );

  modport slave (
    output start, cell_state,
    input  scan_idx, busy, we, wr_idx, wr_val, done, full
  );
endinterface

// File: rtl/empty_scan_ctrl.sv
// empty_scan_ctrl: on a start request, probes the 16 board cells one per
// cycle starting at an offset and writes a new tile into the first empty
// cell (0000 or 1111). If the whole board is occupied, it reports full.
// Optional feature macro: RANDOM_START_EN -- when defined, an 8-bit LFSR
// supplies the starting offset and chooses between TILE_A and TILE_B;
// when undefined the scan always starts at cell 0 and writes TILE_A.
module empty_scan_ctrl #(
  parameter logic [3:0] TILE_A = 4'b0001,
  parameter logic [3:0] TILE_B = 4'b0010
) (
  input  logic         clk,
  input  logic         rst,
  empty_scan_if.master bus
);

  typedef enum logic [1:0] {IDLE, SCAN, PLACE, FIN} state_t;

  state_t     state_q, state_d;
  logic [3:0] scan_idx_q, scan_idx_d;
  logic [3:0] k_q, k_d;
  logic [3:0] wr_idx_q, wr_idx_d;
  logic [3:0] wr_val_q, wr_val_d;
  logic       full_q, full_d;
  logic [3:0] offset;
  logic [3:0] tile_sel;

  function automatic logic is_empty(input logic [3:0] c);
    return (c == 4'b0000) || (c == 4'b1111);
  endfunction

`ifdef RANDOM_START_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       sel_q, sel_d;

  // Fibonacci LFSR, taps 8,6,5,4, free-running in every state
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    sel_d  = sel_q;
    if (state_q == IDLE && bus.start) sel_d = lfsr_q[4];
  end

  // LFSR and spawn-select registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
      sel_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      sel_q  <= sel_d;
    end
  end

  assign offset   = lfsr_q[3:0];
  assign tile_sel = sel_q ? TILE_B : TILE_A;
`else
  assign offset   = 4'd0;
  assign tile_sel = TILE_A;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      scan_idx_q <= 4'd0;
      k_q        <= 4'd0;
      wr_idx_q   <= 4'd0;
      wr_val_q   <= 4'd0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      k_q        <= k_d;
      wr_idx_q   <= wr_idx_d;
      wr_val_q   <= wr_val_d;
      full_q     <= full_d;
    end
  end

  // Next-state logic: scan_idx tracks offset+k, so it wraps naturally at 4 bits
  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    k_d        = k_q;
    wr_idx_d   = wr_idx_q;
    wr_val_d   = wr_val_q;
    full_d     = full_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = SCAN;
          scan_idx_d = offset;
          k_d        = 4'd0;
          full_d     = 1'b0;
        end
      end
      SCAN: begin
        if (is_empty(bus.cell_state)) begin
          wr_idx_d = scan_idx_q;
          wr_val_d = tile_sel;
          state_d  = PLACE;
        end else if (k_q == 4'd15) begin
          full_d  = 1'b1;
          state_d = FIN;
        end else begin
          k_d        = k_q + 4'd1;
          scan_idx_d = scan_idx_q + 4'd1;
        end
      end
      PLACE:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.scan_idx = scan_idx_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.we       = (state_q == PLACE);
  assign bus.wr_idx   = wr_idx_q;
  assign bus.wr_val   = wr_val_q;
  assign bus.done     = (state_q == FIN);
  assign bus.full     = full_q;

endmodule

// File: doc/empty_scan_ctrl.md
EMPTY_SCAN_CTRL -- requirements
Module: empty_scan_ctrl

Interface
REQ-001 SHALL have parameter TILE_A, default 4'b0001, value written when the spawn-select bit is 0.
REQ-002 SHALL have parameter TILE_B, default 4'b0010, value written when the spawn-select bit is 1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to place one new tile.
REQ-006 SHALL have port cell_state, input, 4, contents of the cell addressed by scan_idx, valid combinationally in the same cycle.
REQ-007 SHALL have port scan_idx, output, 4, cell index (0..15) presented to the board selector.
REQ-008 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-009 SHALL have port we, output, 1, one-cycle write strobe to the board.
REQ-010 SHALL have port wr_idx, output, 4, target cell of the write, valid when we=1.
REQ-011 SHALL have port wr_val, output, 4, tile value to write, valid when we=1.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port full, output, 1, set with done when no empty cell exists; held until the next accepted start.

Function
REQ-014 SHALL treat a cell as empty when cell_state is 4'b0000 or 4'b1111.
REQ-015 SHALL implement FSM states IDLE, SCAN, PLACE, FIN.
REQ-016 IDLE: start=1 -> SCAN; capture offset, step counter k=0, clear full.
REQ-017 SCAN: scan_idx = (offset + k) mod 16 (4-bit wrap, 15+1 -> 0); one cell evaluated per cycle.
REQ-018 SCAN: empty cell found -> latch wr_idx=scan_idx, go to PLACE; else k=15 -> set full, go to FIN; else k+1.
REQ-019 PLACE: we=1 for exactly one cycle with latched wr_idx/wr_val; then FIN.
REQ-020 FIN: done=1 for exactly one cycle; then IDLE.
REQ-021 Latency: empty cell found on k-th probe (k=0..15) -> we in cycle k+2 after the start cycle, done in cycle k+3; no empty cell -> done in cycle 17, we never asserted.
REQ-022 start while not in IDLE SHALL be ignored (no queuing).
REQ-023 start in the same cycle as done SHALL be ignored; accepted only in IDLE.
REQ-024 In IDLE, scan_idx SHALL hold its last value; we and done SHALL be 0.
REQ-025 An 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL advance every cycle regardless of state.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, scan_idx=0, busy=0, we=0, wr_idx=0, wr_val=0, done=0, full=0, k=0, LFSR=8'hA5.
REQ-027 rst asserted mid-scan or in PLACE SHALL abort without any write; no done pulse on release.

Configuration
REQ-028 Macro RANDOM_START_EN defined: offset = LFSR[3:0] and spawn-select = LFSR[4], both captured at the accepted start.
REQ-029 Macro RANDOM_START_EN undefined: offset = 0, wr_val always TILE_A, LFSR logic omitted.

Verification (RANDOM_START_EN undefined unless stated)
REQ-030 All cells 4'h3 except cell 5 = 4'h0, start -> scan_idx 0..5, we with wr_idx=5, wr_val=4'h1, done one cycle later, full=0.
REQ-031 All cells 4'h2, start -> 16 probes, scan_idx 15 then done in cycle 17, full=1, we never asserted.
REQ-032 Cell 0 = 4'hF, start -> we in cycle 2 with wr_idx=0; done in cycle 3.
REQ-033 Second start pulsed during SCAN -> ignored; exactly one we and one done per accepted start.
REQ-034 rst pulsed while scan_idx=7 -> all outputs 0 immediately, no we, no done after release.
REQ-035 RANDOM_START_EN defined, after reset 3 cycles then start, only cell 2 empty -> scan_idx begins at the captured LFSR[3:0], wraps 15->0, we at wr_idx=2, wr_val equals TILE_A/TILE_B per captured LFSR[4].
